mul_share_arbiter: RTL

Round-robin arbiter and sequencer that shares one sequential shift-add multiplier core between N_REQ requesters. It accepts operand pairs over a req/gnt handshake and issues a one-cycle start to the core. It waits for core done, bounded by a timeout, and returns the 2*WIDTH-bit product to the owning requester with a one-cycle response pulse. Operations with a zero operand are answered directly without occupying the core.

---
 rtl/mul_share_if.sv | 33 +++
 rtl/mul_share_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mul_share_if.sv
// Bundle between the multiplier-sharing arbiter, its requesters and the shared core.
// slave is the arbiter's view; master is the requester/core side.
interface mul_share_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       rsp_valid;
    logic [2*WIDTH-1:0]     rsp_product;
    logic                   rsp_err;
    logic                   busy;
    logic                   core_start;
    logic [WIDTH-1:0]       core_a;
    logic [WIDTH-1:0]       core_b;
    logic                   core_abort;
    logic                   core_done;
    logic [2*WIDTH-1:0]     core_product;

    modport slave (
        input  req, req_a, req_b, core_done, core_product,
        output gnt, rsp_valid, rsp_product, rsp_err, busy,
               core_start, core_a, core_b, core_abort
    );

    modport master (
        output req, req_a, req_b, core_done, core_product,
        input  gnt, rsp_valid, rsp_product, rsp_err, busy,
               core_start, core_a, core_b, core_abort
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier core among N_REQ requesters,
// with a zero-operand bypass and a bounded wait for the core's done pulse.
module mul_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    mul_share_if.slave  bus
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, BYPASS} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [2*WIDTH-1:0] rsp_product_q, rsp_product_d;
    logic               rsp_err_q, rsp_err_d;
    logic               busy_q, busy_d;
    logic               core_start_q, core_start_d;
    logic [WIDTH-1:0]   core_a_q, core_a_d;
    logic [WIDTH-1:0]   core_b_q, core_b_d;
    logic               core_abort_q, core_abort_d;

    logic               found;
    logic [PTR_W-1:0]   winner;
    logic [WIDTH-1:0]   win_a;
    logic [WIDTH-1:0]   win_b;

    // Scan req starting at rr_ptr, wrapping, and take the first set bit.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
        win_a = bus.req_a[winner*WIDTH +: WIDTH];
        win_b = bus.req_b[winner*WIDTH +: WIDTH];
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        timer_d       = timer_q;
        gnt_d         = '0;
        rsp_valid_d   = '0;
        rsp_product_d = rsp_product_q;
        rsp_err_d     = rsp_err_q;
        core_start_d  = 1'b0;
        core_a_d      = core_a_q;
        core_b_d      = core_b_q;
        core_abort_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d    = N_REQ'(1) << winner;
                    owner_d  = winner;
                    rr_ptr_d = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
                    if (win_a == '0 || win_b == '0) begin
                        state_d = BYPASS;
                    end else begin
                        core_a_d     = win_a;
                        core_b_d     = win_b;
                        core_start_d = 1'b1;
                        timer_d      = '0;
                        state_d      = WAIT;
                    end
                end
            end
            BYPASS: begin
                rsp_valid_d   = N_REQ'(1) << owner_q;
                rsp_product_d = '0;
                rsp_err_d     = 1'b0;
                state_d       = IDLE;
            end
            WAIT: begin
                // A done seen while our own start pulse is still out cannot belong to this op.
                if (bus.core_done && !core_start_q) begin
                    rsp_valid_d   = N_REQ'(1) << owner_q;
                    rsp_product_d = bus.core_product;
                    rsp_err_d     = 1'b0;
                    state_d       = IDLE;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    rsp_valid_d   = N_REQ'(1) << owner_q;
                    rsp_product_d = '0;
                    rsp_err_d     = 1'b1;
                    core_abort_d  = 1'b1;
                    state_d       = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            timer_q       <= '0;
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_product_q <= '0;
            rsp_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            core_start_q  <= 1'b0;
            core_a_q      <= '0;
            core_b_q      <= '0;
            core_abort_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            timer_q       <= timer_d;
            gnt_q         <= gnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_product_q <= rsp_product_d;
            rsp_err_q     <= rsp_err_d;
            busy_q        <= busy_d;
            core_start_q  <= core_start_d;
            core_a_q      <= core_a_d;
            core_b_q      <= core_b_d;
            core_abort_q  <= core_abort_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_product = rsp_product_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.busy        = busy_q;
    assign bus.core_start  = core_start_q;
    assign bus.core_a      = core_a_q;
    assign bus.core_b      = core_b_q;
    assign bus.core_abort  = core_abort_q;
endmodule
